// File: rtl/isp_pkg.sv
// Shared pixel constants and morphology mode encoding for the ISP post-processing stages.
package isp_pkg;

   localparam logic [7:0] EDGE_VAL = 8'h00;
   localparam logic [7:0] BG_VAL   = 8'hFF;

   typedef enum logic {
      MORPH_DILATE = 1'b0,
      MORPH_ERODE  = 1'b1
   } morph_mode_e;

endpackage

// File: rtl/edge_morph_3x3_line_buf.sv
// One-bit-wide line memory: one write port and one registered read port.
// A read and a write to the same address in one cycle returns the old contents.
module line_buf_1bit #(
   parameter int DEPTH = 640,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic          wdata,
   input  logic          re,
   input  logic [AW-1:0] rd_addr,
   output logic          rdata
);

   logic mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[wr_addr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         rdata <= 1'b0;
      else if (re)
         rdata <= mem[rd_addr];
   end

endmodule

// File: rtl/edge_morph_3x3.sv
// 3x3 binary dilation/erosion of a Sobel edge map, with a fixed two-clock latency.
// The output pixel at stream position (r,c) is the operation over input rows r-2..r, cols c-2..c.
module edge_morph_3x3
   import isp_pkg::*;
#(
   parameter logic [11:0] H_DISP = 12'd640,
   parameter logic [11:0] V_DISP = 12'd480,
   parameter logic        MODE   = MORPH_DILATE
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sobel_de,
   input  logic       sobel_hsync,
   input  logic       sobel_vsync,
   input  logic [7:0] sobel_data,
   output logic       morph_de,
   output logic       morph_hsync,
   output logic       morph_vsync,
   output logic [7:0] morph_data
);

   localparam int AW = $clog2(int'(H_DISP));

   logic        e;
   logic        de_prev;
   logic        vs_prev;
   logic        de_fall;
   logic        vs_rise;
   logic        pix_ok;
   logic [11:0] col_cnt;
   logic [11:0] row_cnt;
   logic        col_full;

   logic        pix_ok_d1;
   logic [11:0] col_d1;
   logic [11:0] row_d1;
   logic [1:0]  de_dl;
   logic [1:0]  hs_dl;
   logic [1:0]  vs_dl;
   logic [2:0]  win_r;
   logic [1:0]  win_r1;
   logic [1:0]  win_r2;
   logic        lb0_q;
   logic        lb1_q;

   logic [2:0]  col_mask;
   logic [2:0]  tap_r;
   logic [2:0]  tap_r1;
   logic [2:0]  tap_r2;
   logic [8:0]  taps;
   logic        hit;

   assign e       = (sobel_data == EDGE_VAL);
   assign de_fall = de_prev & ~sobel_de;
   assign vs_rise = sobel_vsync & ~vs_prev;
   // Pixels past the last column are neither stored nor allowed to produce an edge.
   assign pix_ok  = sobel_de & ~col_full;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         de_prev  <= 1'b0;
         vs_prev  <= 1'b0;
         col_cnt  <= '0;
         col_full <= 1'b0;
         row_cnt  <= '0;
      end else begin
         de_prev <= sobel_de;
         vs_prev <= sobel_vsync;
         if (de_fall) begin
            col_cnt  <= '0;
            col_full <= 1'b0;
         end else if (pix_ok) begin
            if (col_cnt == H_DISP - 12'd1)
               col_full <= 1'b1;
            else
               col_cnt <= col_cnt + 12'd1;
         end
         if (vs_rise)
            row_cnt <= '0;
         else if (de_fall && (row_cnt != V_DISP - 12'd1))
            row_cnt <= row_cnt + 12'd1;
      end
   end

   // LB1 receives LB0's old word one cycle late, so its write address lags the shared read address.
   line_buf_1bit #(.DEPTH(int'(H_DISP))) u_lb0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (pix_ok),
      .wr_addr (col_cnt[AW-1:0]),
      .wdata   (e),
      .re      (pix_ok),
      .rd_addr (col_cnt[AW-1:0]),
      .rdata   (lb0_q)
   );

   line_buf_1bit #(.DEPTH(int'(H_DISP))) u_lb1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (pix_ok_d1),
      .wr_addr (col_d1[AW-1:0]),
      .wdata   (lb0_q),
      .re      (pix_ok),
      .rd_addr (col_cnt[AW-1:0]),
      .rdata   (lb1_q)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pix_ok_d1 <= 1'b0;
         col_d1    <= '0;
         row_d1    <= '0;
         de_dl     <= '0;
         hs_dl     <= '0;
         vs_dl     <= '0;
         win_r     <= '0;
         win_r1    <= '0;
         win_r2    <= '0;
      end else begin
         pix_ok_d1 <= pix_ok;
         col_d1    <= col_cnt;
         row_d1    <= row_cnt;
         de_dl     <= {de_dl[0], sobel_de};
         hs_dl     <= {hs_dl[0], sobel_hsync};
         vs_dl     <= {vs_dl[0], sobel_vsync};
         if (pix_ok) begin
            win_r  <= {win_r[1:0], e};
            win_r1 <= {win_r1[0], lb0_q};
            win_r2 <= {win_r2[0], lb1_q};
         end
      end
   end

   // Taps outside the image read as background, which hides stale line-buffer words.
   always_comb begin
      col_mask = {(col_d1 >= 12'd2), (col_d1 >= 12'd1), 1'b1};
      tap_r    = win_r & col_mask;
      tap_r1   = {win_r1, lb0_q} & col_mask & {3{row_d1 >= 12'd1}};
      tap_r2   = {win_r2, lb1_q} & col_mask & {3{row_d1 >= 12'd2}};
      taps     = {tap_r2, tap_r1, tap_r};
      hit      = (MODE == MORPH_ERODE) ? (&taps) : (|taps);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         morph_data <= BG_VAL;
      else
         morph_data <= (pix_ok_d1 && hit) ? EDGE_VAL : BG_VAL;
   end

   assign morph_de    = de_dl[1];
   assign morph_hsync = hs_dl[1];
   assign morph_vsync = vs_dl[1];

endmodule
